video_rx_capture: RTL and testbench
===================================

Name: video_rx_capture

Overview:
Receive-side counterpart of the display timing generator. It samples a video_if-style stream (HS, VS, BLANK, RGB) in the pixel_clk domain and measures line and frame timing. It locks when the measured active geometry matches HDISP x VDISP, then pushes active pixels, with start-of-frame and end-of-line markers, into an external async FIFO whose write side is pixel_clk. A downstream Wishbone writer drains that FIFO into SDRAM.

Parameters:
HDISP, 800, active pixels per line expected
VDISP, 480, active lines per frame expected
CNT_W, 12, width of timing measurement counters (saturating)

Ports:
pixel_clk  in  1  pixel clock; all logic in this domain
pixel_rst  in  1  asynchronous, active-high reset
vid_hs  in  1  horizontal sync, active low
vid_vs  in  1  vertical sync, active low
vid_blank  in  1  data enable; 1 = active pixel on vid_rgb this cycle
vid_rgb  in  24  pixel {R,G,B}
pix_write  out  1  FIFO write strobe
pix_wdata  out  32  {6'b0, sof, eol, rgb[23:0]}
pix_wfull  in  1  FIFO full
locked  out  1  1 while in LOCKED state
frame_start  out  1  one-cycle pulse on every detected VS falling edge
h_total  out  CNT_W  last measured pixel_clk cycles between HS falling edges
v_total  out  CNT_W  last measured HS falling edges between VS falling edges
err_hsize  out  1  sticky: active run length != HDISP while LOCKED
err_vsize  out  1  sticky: active line count != VDISP at frame end while LOCKED
err_ovf  out  1  sticky: active pixel arrived with pix_wfull=1

Behaviour:
- Reset: all outputs 0; input registers set to hs=1, vs=1, blank=0; state SEARCH; all counters 0. Reset mid-frame discards the frame; no partial write after release.
- Input stage: vid_* registered once (s1), then again (s2). Edges are taken from s1 vs s2. HS fall = s2_hs & ~s1_hs; VS fall likewise.
- Data path: pix_write and pix_wdata are registered from s1, two pixel_clk cycles after the pins.
- Counters:
  - hcnt: counts cycles and loads h_total at HS fall.
  - xcnt: counts s1_blank cycles; cleared at HS fall. A line is active if xcnt > 0 at its end, which is the falling edge of blank.
  - ycnt: counts active lines; cleared at VS fall.
  - vcnt: counts HS falls and loads v_total at VS fall.
  - All counters saturate at 2^CNT_W-1.
- States:
  - SEARCH: no writes. VS fall -> MEASURE.
  - MEASURE: no writes. Every active run must equal HDISP; a mismatch -> SEARCH, with no sticky error. At the next VS fall: ycnt==VDISP -> LOCKED, else stay MEASURE (re-measure next frame).
  - LOCKED: locked=1. Each s1_blank cycle with pix_wfull=0 and no skip pending produces pix_write=1.
    - sof=1 on the first pixel after VS fall (x=0, y=0).
    - eol=1 on pixel x=HDISP-1.
    - Run length != HDISP at blank fall -> err_hsize=1, state SEARCH.
    - VS fall with ycnt != VDISP -> err_vsize=1, state SEARCH. That VS fall is not reused to re-enter MEASURE.
- Overflow: in LOCKED, s1_blank=1 with pix_wfull=1 -> no write, err_ovf=1, skip=1. While skip=1, all writes are suppressed until the next VS fall clears it, so the downstream writer never sees a torn frame. The state stays LOCKED.
- Simultaneous events:
  - HS and VS falling in the same cycle: process HS first (close the line), then VS.
  - Blank fall coinciding with VS fall: the run check happens before the ycnt check, and the line is counted.
- Sticky errors clear only on pixel_rst.
- frame_start pulses in every state.

Test Plan:
- Nominal 928x525 timing (HFP 40, HPULSE 48, HBP 40, VFP 13, VPULSE 3, VBP 29), pix_wfull=0, rgb = counter -> frame 1 no writes; frame 2 locked=1 and exactly 384000 writes; first pixel sof=1; every 800th pixel eol=1; h_total=928, v_total=525; no errors.
- Locked, then one line with 799 active pixels -> err_hsize=1, locked=0 in the cycle after blank fall; relock needs 2 clean VS falls.
- Locked, then a frame with 479 active lines -> err_vsize=1 at VS fall, no further writes until relock.
- pix_wfull=1 for 3 cycles mid-line in frame 3 -> err_ovf=1, writes stop; next frame writes resume with sof=1; locked stays 1.
- pixel_rst asserted for 2 cycles mid-line while locked -> all outputs 0 immediately; after release, no write before SEARCH->MEASURE->LOCKED.
- Geometry 640x480 input with defaults -> never locked, pix_write never 1, sticky errors stay 0, h_total reflects the input line length.

Source files
------------

// File: rtl/video_rx_capture.sv
// Video receive capture: measures line/frame timing of an HS/VS/BLANK/RGB stream,
// locks onto the expected active geometry and pushes active pixels into a FIFO.
module video_rx_capture #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int CNT_W = 12
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic             vid_hs,
  input  logic             vid_vs,
  input  logic             vid_blank,
  input  logic [23:0]      vid_rgb,
  output logic             pix_write,
  output logic [31:0]      pix_wdata,
  input  logic             pix_wfull,
  output logic             locked,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic             err_hsize,
  output logic             err_vsize,
  output logic             err_ovf
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HDISP_C = CNT_W'(HDISP);
  localparam logic [CNT_W-1:0] VDISP_C = CNT_W'(VDISP);
  localparam logic [CNT_W-1:0] EOL_C   = CNT_W'(HDISP - 1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + ONE_C;
  endfunction

  logic             s1_hs_r, s1_vs_r, s1_blank_r;
  logic [23:0]      s1_rgb_r;
  logic             s2_hs_r, s2_vs_r, s2_blank_r;
  logic [CNT_W-1:0] hcnt_r, xcnt_r, ycnt_r, vcnt_r;
  logic [CNT_W-1:0] h_total_r, v_total_r;
  state_t           state_r, state_next_s;
  logic             skip_r, sof_pend_r;
  logic             pix_write_r, locked_r, frame_start_r;
  logic [31:0]      pix_wdata_r;
  logic             err_hsize_r, err_vsize_r, err_ovf_r;

  logic             hs_fall_s, vs_fall_s, blank_fall_s;
  logic             line_end_s, run_bad_s, frame_bad_s;
  logic [CNT_W-1:0] ycnt_eff_s, vcnt_eff_s;
  logic             skip_eff_s, sof_s, eol_s;
  logic             write_s, ovf_s, hsize_err_s, vsize_err_s;

  assign hs_fall_s    = s2_hs_r & ~s1_hs_r;
  assign vs_fall_s    = s2_vs_r & ~s1_vs_r;
  assign blank_fall_s = s2_blank_r & ~s1_blank_r;

  // A line closing on the same cycle as VS fall still counts toward this frame.
  assign line_end_s  = blank_fall_s & (xcnt_r != ZERO_C);
  assign run_bad_s   = blank_fall_s & (xcnt_r != HDISP_C);
  assign ycnt_eff_s  = line_end_s ? sat_inc(ycnt_r) : ycnt_r;
  assign frame_bad_s = vs_fall_s & (ycnt_eff_s != VDISP_C);
  assign vcnt_eff_s  = hs_fall_s ? sat_inc(vcnt_r) : vcnt_r;

  assign skip_eff_s = skip_r & ~vs_fall_s;
  assign sof_s      = sof_pend_r | vs_fall_s;
  assign eol_s      = (xcnt_r == EOL_C);

  // Next state, write strobe and error events.
  always_comb begin
    state_next_s = state_r;
    write_s      = 1'b0;
    ovf_s        = 1'b0;
    hsize_err_s  = 1'b0;
    vsize_err_s  = 1'b0;
    case (state_r)
      SEARCH: begin
        if (vs_fall_s) state_next_s = MEASURE;
        else           state_next_s = SEARCH;
      end
      MEASURE: begin
        if (run_bad_s)                      state_next_s = SEARCH;
        else if (vs_fall_s && !frame_bad_s) state_next_s = LOCKED;
        else                                state_next_s = MEASURE;
      end
      LOCKED: begin
        ovf_s   = s1_blank_r & pix_wfull;
        write_s = s1_blank_r & ~pix_wfull & ~skip_eff_s;
        if (run_bad_s) begin
          hsize_err_s  = 1'b1;
          state_next_s = SEARCH;
        end else if (frame_bad_s) begin
          vsize_err_s  = 1'b1;
          state_next_s = SEARCH;
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: state_next_s = SEARCH;
    endcase
  end

  // Input synchronisation stages, counters, state and output registers.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      s1_hs_r       <= 1'b1;
      s1_vs_r       <= 1'b1;
      s1_blank_r    <= 1'b0;
      s1_rgb_r      <= 24'd0;
      s2_hs_r       <= 1'b1;
      s2_vs_r       <= 1'b1;
      s2_blank_r    <= 1'b0;
      hcnt_r        <= ZERO_C;
      xcnt_r        <= ZERO_C;
      ycnt_r        <= ZERO_C;
      vcnt_r        <= ZERO_C;
      h_total_r     <= ZERO_C;
      v_total_r     <= ZERO_C;
      state_r       <= SEARCH;
      skip_r        <= 1'b0;
      sof_pend_r    <= 1'b0;
      pix_write_r   <= 1'b0;
      pix_wdata_r   <= 32'd0;
      locked_r      <= 1'b0;
      frame_start_r <= 1'b0;
      err_hsize_r   <= 1'b0;
      err_vsize_r   <= 1'b0;
      err_ovf_r     <= 1'b0;
    end else begin
      s1_hs_r    <= vid_hs;
      s1_vs_r    <= vid_vs;
      s1_blank_r <= vid_blank;
      s1_rgb_r   <= vid_rgb;
      s2_hs_r    <= s1_hs_r;
      s2_vs_r    <= s1_vs_r;
      s2_blank_r <= s1_blank_r;

      // hcnt restarts at 1 so that h_total is the full edge-to-edge period.
      if (hs_fall_s) begin
        h_total_r <= hcnt_r;
        hcnt_r    <= ONE_C;
        xcnt_r    <= s1_blank_r ? ONE_C : ZERO_C;
      end else begin
        hcnt_r    <= sat_inc(hcnt_r);
        xcnt_r    <= s1_blank_r ? sat_inc(xcnt_r) : xcnt_r;
      end

      if (vs_fall_s) begin
        v_total_r <= vcnt_eff_s;
        vcnt_r    <= ZERO_C;
        ycnt_r    <= ZERO_C;
      end else begin
        vcnt_r    <= vcnt_eff_s;
        ycnt_r    <= ycnt_eff_s;
      end

      if (ovf_s)          skip_r <= 1'b1;
      else if (vs_fall_s) skip_r <= 1'b0;
      else                skip_r <= skip_r;

      if (vs_fall_s)       sof_pend_r <= ~s1_blank_r;
      else if (s1_blank_r) sof_pend_r <= 1'b0;
      else                 sof_pend_r <= sof_pend_r;

      state_r       <= state_next_s;
      locked_r      <= (state_next_s == LOCKED);
      frame_start_r <= vs_fall_s;
      pix_write_r   <= write_s;
      if (write_s) pix_wdata_r <= {6'd0, sof_s, eol_s, s1_rgb_r};
      else         pix_wdata_r <= pix_wdata_r;

      err_hsize_r <= err_hsize_r | hsize_err_s;
      err_vsize_r <= err_vsize_r | vsize_err_s;
      err_ovf_r   <= err_ovf_r | ovf_s;
    end
  end

  assign pix_write   = pix_write_r;
  assign pix_wdata   = pix_wdata_r;
  assign locked      = locked_r;
  assign frame_start = frame_start_r;
  assign h_total     = h_total_r;
  assign v_total     = v_total_r;
  assign err_hsize   = err_hsize_r;
  assign err_vsize   = err_vsize_r;
  assign err_ovf     = err_ovf_r;

endmodule

// File: tb/tb_video_rx_capture.sv
// Directed bench for video_rx_capture on a reduced 8x4 geometry
// (line 14 clocks: 8 active, HFP 2, HS 2, HBP 2; frame 7 lines: VS 1, VBP 1, 4 active, VFP 1).
module tb_video_rx_capture;

  localparam int HD  = 8;
  localparam int VD  = 4;
  localparam int HFP = 2;
  localparam int HPW = 2;
  localparam int HBP = 2;
  localparam int VPW = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;

  logic        clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        vid_hs = 1'b1;
  logic        vid_vs = 1'b1;
  logic        vid_blank = 1'b0;
  logic [23:0] vid_rgb = 24'd0;
  logic        pix_wfull = 1'b0;
  logic        pix_write;
  logic [31:0] pix_wdata;
  logic        locked;
  logic        frame_start;
  logic [11:0] h_total;
  logic [11:0] v_total;
  logic        err_hsize;
  logic        err_vsize;
  logic        err_ovf;

  video_rx_capture #(.HDISP(HD), .VDISP(VD), .CNT_W(12)) dut (
    .pixel_clk  (clk),
    .pixel_rst  (pixel_rst),
    .vid_hs     (vid_hs),
    .vid_vs     (vid_vs),
    .vid_blank  (vid_blank),
    .vid_rgb    (vid_rgb),
    .pix_write  (pix_write),
    .pix_wdata  (pix_wdata),
    .pix_wfull  (pix_wfull),
    .locked     (locked),
    .frame_start(frame_start),
    .h_total    (h_total),
    .v_total    (v_total),
    .err_hsize  (err_hsize),
    .err_vsize  (err_vsize),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: pixel index within the frame restarts at every sof.
  int   writes = 0, sofs = 0, eols = 0, eol_bad = 0, data_bad = 0;
  int   fs_cnt = 0, lock_cyc = 0, t_cyc = 0, t_hs = -1, t_lf = -2, p_r = 0;
  logic prev_lock = 1'b0, prev_hs = 1'b0;
  int   pidx;
  assign pidx = pix_wdata[25] ? 0 : p_r;

  always @(negedge clk) begin
    t_cyc     <= t_cyc + 1;
    prev_lock <= locked;
    prev_hs   <= err_hsize;
    if (!locked && prev_lock) t_lf <= t_cyc;
    if (err_hsize && !prev_hs) t_hs <= t_cyc;
    if (frame_start) fs_cnt <= fs_cnt + 1;
    if (locked) lock_cyc <= lock_cyc + 1;
    if (pix_write) begin
      writes <= writes + 1;
      p_r    <= pidx + 1;
      if (pix_wdata[25]) sofs <= sofs + 1;
      if (pix_wdata[24]) eols <= eols + 1;
      if (pix_wdata[24] != ((pidx % HD) == HD - 1)) eol_bad <= eol_bad + 1;
      if (pix_wdata[15:0] != {8'(pidx / HD), 8'(pidx % HD)} || pix_wdata[31:26] != 6'd0)
        data_bad <= data_bad + 1;
    end
  end

  int frame_no = 0;
  int w_rel = 0;

  // One frame; short_y shortens that active line by one pixel, full_y raises
  // pix_wfull on pins h=3..5 of that line, rst_cyc pulses reset for 2 clocks.
  task automatic run_frame(input int hd, input int vd, input int short_y,
                           input int full_y, input int rst_cyc);
    int ht, vt, ya, len, cyc;
    ht = hd + HFP + HPW + HBP;
    vt = VPW + VBP + vd + VFP;
    for (int v = 0; v < vt; v++) begin
      for (int h = 0; h < ht; h++) begin
        @(posedge clk);
        #1;
        ya  = v - (VPW + VBP);
        len = (ya == short_y) ? hd - 1 : hd;
        cyc = v * ht + h;
        vid_blank = (ya >= 0) && (ya < vd) && (h < len);
        vid_hs    = !((h >= hd + HFP) && (h < hd + HFP + HPW));
        vid_vs    = !(v < VPW);
        vid_rgb   = {8'(frame_no), 8'(ya), 8'(h)};
        pix_wfull = (ya == full_y) && (h >= 3) && (h < 6);
        if (cyc == rst_cyc) begin
          pixel_rst = 1'b1;
          #1;
          check("rst_locked", locked, 0);
          check("rst_outs", {pix_write, pix_wdata, frame_start, h_total, v_total,
                             err_hsize, err_vsize, err_ovf}, 0);
        end else if (cyc == rst_cyc + 2) begin
          pixel_rst = 1'b0;
          w_rel = writes;
        end
      end
    end
    frame_no++;
  endtask

  int w0, s0, e0, f0, l0;

  task automatic snap();
    w0 = writes; s0 = sofs; e0 = eols; f0 = fs_cnt; l0 = lock_cyc;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {locked, pix_write, pix_wdata, frame_start, h_total, v_total,
                         err_hsize, err_vsize, err_ovf}, 0);
    pixel_rst = 1'b0;

    // Frame 1: VS fall moves SEARCH->MEASURE, nothing written.
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f1_writes", writes - w0, 0);
    check("f1_locked", locked, 0);
    check("f1_h_total", h_total, 14);

    // Frame 2: locked for the whole frame.
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f2_locked", locked, 1);
    check("f2_writes", writes - w0, 32);
    check("f2_sof", sofs - s0, 1);
    check("f2_eol", eols - e0, 4);
    check("f2_v_total", v_total, 7);
    check("f2_h_total", h_total, 14);
    check("f2_fs", fs_cnt - f0, 1);
    check("f2_errs", {err_hsize, err_vsize, err_ovf}, 0);

    // Frame 3: line 1 has 7 pixels.
    snap();
    run_frame(HD, VD, 1, -1, -1);
    check("f3_writes", writes - w0, 15);
    check("f3_err_hsize", err_hsize, 1);
    check("f3_locked", locked, 0);
    check("f3_lock_drop_cycle", t_lf, t_hs);

    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f4_writes", writes - w0, 0);
    check("f4_locked", locked, 0);
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f5_writes", writes - w0, 32);
    check("f5_locked", locked, 1);

    // Frame 6: only 3 active lines; detected at frame 7's VS fall.
    snap();
    run_frame(HD, VD - 1, -1, -1, -1);
    check("f6_writes", writes - w0, 24);
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f7_err_vsize", err_vsize, 1);
    check("f7_writes", writes - w0, 0);
    check("f7_locked", locked, 0);
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f8_writes", writes - w0, 0);
    check("f8_locked", locked, 0);
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f9_writes", writes - w0, 32);
    check("f9_locked", locked, 1);

    // Frame 10: FIFO full hits pixel x=2 of line 2.
    snap();
    run_frame(HD, VD, -1, 2, -1);
    check("f10_writes", writes - w0, 18);
    check("f10_err_ovf", err_ovf, 1);
    check("f10_locked", locked, 1);
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("f11_writes", writes - w0, 32);
    check("f11_sof", sofs - s0, 1);
    check("f11_locked", locked, 1);

    // Frame 12: reset mid active line 2; relock takes two more VS falls.
    run_frame(HD, VD, -1, -1, 59);
    run_frame(HD, VD, -1, -1, -1);
    check("rst_no_early_write", writes - w_rel, 0);
    check("rst_f13_locked", locked, 0);
    snap();
    run_frame(HD, VD, -1, -1, -1);
    check("rst_f14_writes", writes - w0, 32);
    check("rst_f14_sof", sofs - s0, 1);
    check("rst_f14_errs", {err_hsize, err_vsize, err_ovf}, 0);

    check("eol_position", eol_bad, 0);
    check("pixel_data", data_bad, 0);

    // 6-pixel lines never match the expected 8-pixel geometry.
    pixel_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pixel_rst = 1'b0;
    snap();
    for (int f = 0; f < 3; f++) run_frame(6, VD, -1, -1, -1);
    check("geo_locked_cycles", lock_cyc - l0, 0);
    check("geo_writes", writes - w0, 0);
    check("geo_errs", {err_hsize, err_vsize, err_ovf}, 0);
    check("geo_h_total", h_total, 12);
    check("geo_v_total", v_total, 7);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
